handshake_rr_arbiter: RTL and testbench

HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

---
 rtl/handshake_rr_arbiter_pkg.sv | 24 ++
 rtl/handshake_fifo.sv | 85 ++++++++
 rtl/handshake_rr_arbiter.sv | 91 +++++++++
 tb/tb_handshake_rr_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_rr_arbiter_pkg.sv
// Shared types and default sizing for the round-robin handshake arbiter and its output FIFO.
package handshake_rr_arbiter_pkg;

   localparam int NUM_IN = 3;
   localparam int WIDTH  = 4;
   localparam int DEPTH  = 2;
   localparam int SRC_W  = 2;

   typedef logic [SRC_W-1:0] src_t;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      src_t             src;
   } entry_t;

   // Next round-robin start position after channel idx wins, wrapping at n.
   function automatic src_t rr_next(src_t idx, int n);
      if (int'(idx) >= n - 1) begin
         return '0;
      end
      return idx + src_t'(1);
   endfunction

endpackage

// File: rtl/handshake_fifo.sv
// Output FIFO holding {data, src} entries; head is forced to zero while empty.
module handshake_fifo
   import handshake_rr_arbiter_pkg::*;
#(
   parameter int unsigned DataW = 4,
   parameter int unsigned Depth = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [DataW-1:0] push_data_i,
   input  src_t             push_src_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             valid_o,
   output logic [DataW-1:0] head_data_o,
   output src_t             head_src_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   typedef logic [PtrW-1:0] ptr_t;

   logic [DataW-1:0] data_q [Depth];
   src_t             src_q  [Depth];
   ptr_t             wr_ptr_q, wr_ptr_d;
   ptr_t             rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             full, empty, do_push, do_pop;

   function automatic ptr_t ptr_inc(ptr_t p);
      if (p == ptr_t'(Depth - 1)) begin
         return '0;
      end
      return p + ptr_t'(1);
   endfunction

   always_comb begin
      full     = (count_q == CntW'(Depth));
      empty    = (count_q == '0);
      // A pop never frees a slot for a push in the same cycle.
      do_push  = push_i & ~full;
      do_pop   = pop_i & ~empty;
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && do_push) begin
         data_q[wr_ptr_q] <= push_data_i;
         src_q[wr_ptr_q]  <= push_src_i;
      end
   end

   always_comb begin
      full_o      = full;
      valid_o     = ~empty;
      head_data_o = '0;
      head_src_o  = '0;
      if (!empty) begin
         head_data_o = data_q[rd_ptr_q];
         head_src_o  = src_q[rd_ptr_q];
      end
   end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter merging NUM_IN valid/ready channels into one buffered output stream.
module handshake_rr_arbiter
   import handshake_rr_arbiter_pkg::src_t;
   import handshake_rr_arbiter_pkg::rr_next;
#(
   parameter int NUM_IN = handshake_rr_arbiter_pkg::NUM_IN,
   parameter int WIDTH  = handshake_rr_arbiter_pkg::WIDTH,
   parameter int DEPTH  = handshake_rr_arbiter_pkg::DEPTH
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [NUM_IN-1:0]       handshake_arr_valid,
   output logic [NUM_IN-1:0]       handshake_arr_ready,
   input  logic [NUM_IN*WIDTH-1:0] handshake_arr_data,
   output logic                    handshake_valid,
   input  logic                    handshake_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [1:0]              out_src,
   output logic [7:0]              xfer_count
);

   src_t             rr_ptr_q, rr_ptr_d;
   src_t             gnt_idx;
   logic             gnt_vld;
   logic             fifo_full;
   logic             push, pop;
   logic [WIDTH-1:0] push_data;
   src_t             head_src;
   logic [7:0]       xfer_q, xfer_d;

   // First valid channel at or after rr_ptr_q, searching upward modulo NUM_IN.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (!gnt_vld && handshake_arr_valid[i] && (i == (int'(rr_ptr_q) + k) % NUM_IN)) begin
               gnt_vld = 1'b1;
               gnt_idx = src_t'(i);
            end
         end
      end
   end

   always_comb begin
      handshake_arr_ready = '0;
      push_data           = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (gnt_idx == src_t'(i)) begin
            handshake_arr_ready[i] = gnt_vld & ~fifo_full;
            push_data              = handshake_arr_data[i*WIDTH +: WIDTH];
         end
      end
      push     = |(handshake_arr_valid & handshake_arr_ready);
      pop      = handshake_valid & handshake_ready;
      rr_ptr_d = push ? rr_next(gnt_idx, NUM_IN) : rr_ptr_q;
      xfer_d   = pop ? xfer_q + 8'd1 : xfer_q;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rr_ptr_q <= '0;
         xfer_q   <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         xfer_q   <= xfer_d;
      end
   end

   handshake_fifo #(
      .DataW (WIDTH),
      .Depth (DEPTH)
   ) u_fifo (
      .clk_i       (CLK),
      .rst_i       (RESET),
      .push_i      (push),
      .push_data_i (push_data),
      .push_src_i  (gnt_idx),
      .pop_i       (pop),
      .full_o      (fifo_full),
      .valid_o     (handshake_valid),
      .head_data_o (out_data),
      .head_src_o  (head_src)
   );

   assign out_src    = head_src;
   assign xfer_count = xfer_q;

   a_ready_onehot: assert property (@(posedge CLK) $onehot0(handshake_arr_ready));

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter with NUM_IN=3, WIDTH=4, DEPTH=2.
module tb_handshake_rr_arbiter;

   logic        CLK;
   logic        RESET;
   logic [2:0]  arr_valid;
   logic [2:0]  arr_ready;
   logic [11:0] arr_data;
   logic        hvalid;
   logic        hready;
   logic [3:0]  out_data;
   logic [1:0]  out_src;
   logic [7:0]  xfer_count;

   int n_cmp;
   int n_err;

   handshake_rr_arbiter #(
      .NUM_IN (3),
      .WIDTH  (4),
      .DEPTH  (2)
   ) dut (
      .CLK                 (CLK),
      .RESET               (RESET),
      .handshake_arr_valid (arr_valid),
      .handshake_arr_ready (arr_ready),
      .handshake_arr_data  (arr_data),
      .handshake_valid     (hvalid),
      .handshake_ready     (hready),
      .out_data            (out_data),
      .out_src             (out_src),
      .xfer_count          (xfer_count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Advance one clock and sample just after the edge.
   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET     = 1'b1;
      arr_valid = 3'b000;
      hready    = 1'b0;
      cycle();
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      RESET     = 1'b1;
      arr_valid = 3'b000;
      hready    = 1'b0;
      cycle();
      n_cmp++; if (hvalid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", hvalid); end
      n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
      n_cmp++; if (out_src !== 2'd0) begin n_err++; $display("FAIL reset_src: got %0d want 0", out_src); end
      n_cmp++; if (xfer_count !== 8'd0) begin n_err++; $display("FAIL reset_xfer: got %0d want 0", xfer_count); end
      n_cmp++; if (arr_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b want 000", arr_ready); end
      RESET     = 1'b0;
      arr_valid = 3'b100;
      #1;
      n_cmp++; if (arr_ready !== 3'b100) begin n_err++; $display("FAIL reset_grant2: got %b want 100", arr_ready); end
      arr_valid = 3'b000;
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_rdy;
      logic [3:0] exp_dat;
      do_reset();
      arr_valid = 3'b111;
      hready    = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         exp_rdy = 3'b001 << (k % 3);
         exp_dat = 4'(10 + k % 3);
         n_cmp++; if (arr_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", k, arr_ready, exp_rdy); end
         cycle();
         n_cmp++; if (hvalid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b want 1", k, hvalid); end
         n_cmp++; if (out_src !== 2'(k % 3)) begin n_err++; $display("FAIL rr_src[%0d]: got %0d want %0d", k, out_src, k % 3); end
         n_cmp++; if (out_data !== exp_dat) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", k, out_data, exp_dat); end
         n_cmp++; if (xfer_count !== 8'(k)) begin n_err++; $display("FAIL rr_xfer[%0d]: got %0d want %0d", k, xfer_count, k); end
      end
      arr_valid = 3'b000;
      cycle();
   endtask

   task automatic test_stall_order();
      do_reset();
      arr_valid = 3'b101;
      hready    = 1'b0;
      #1;
      n_cmp++; if (arr_ready !== 3'b001) begin n_err++; $display("FAIL so_ready0: got %b want 001", arr_ready); end
      cycle();
      n_cmp++; if (out_src !== 2'd0) begin n_err++; $display("FAIL so_src0: got %0d want 0", out_src); end
      #1;
      n_cmp++; if (arr_ready !== 3'b100) begin n_err++; $display("FAIL so_ready1: got %b want 100", arr_ready); end
      cycle();
      n_cmp++; if (arr_ready !== 3'b000) begin n_err++; $display("FAIL so_full_ready: got %b want 000", arr_ready); end
      n_cmp++; if (out_data !== 4'hA) begin n_err++; $display("FAIL so_head: got %h want a", out_data); end
      hready = 1'b1;
      #1;
      n_cmp++; if (arr_ready !== 3'b000) begin n_err++; $display("FAIL so_no_passthru: got %b want 000", arr_ready); end
      arr_valid = 3'b000;
      cycle();
      n_cmp++; if (out_src !== 2'd2) begin n_err++; $display("FAIL so_pop2_src: got %0d want 2", out_src); end
      n_cmp++; if (out_data !== 4'hC) begin n_err++; $display("FAIL so_pop2_data: got %h want c", out_data); end
      n_cmp++; if (hvalid !== 1'b1) begin n_err++; $display("FAIL so_pop2_valid: got %b want 1", hvalid); end
      cycle();
      n_cmp++; if (hvalid !== 1'b0) begin n_err++; $display("FAIL so_empty: got %b want 0", hvalid); end
      n_cmp++; if (xfer_count !== 8'd2) begin n_err++; $display("FAIL so_xfer: got %0d want 2", xfer_count); end
   endtask

   task automatic test_full_pop();
      do_reset();
      arr_valid = 3'b001;
      hready    = 1'b0;
      cycle();
      cycle();
      arr_valid = 3'b010;
      hready    = 1'b1;
      #1;
      n_cmp++; if (arr_ready !== 3'b000) begin n_err++; $display("FAIL fp_ready_n: got %b want 000", arr_ready); end
      cycle();
      n_cmp++; if (out_src !== 2'd0) begin n_err++; $display("FAIL fp_src_n: got %0d want 0", out_src); end
      n_cmp++; if (xfer_count !== 8'd1) begin n_err++; $display("FAIL fp_xfer_n: got %0d want 1", xfer_count); end
      #1;
      n_cmp++; if (arr_ready !== 3'b010) begin n_err++; $display("FAIL fp_ready_n1: got %b want 010", arr_ready); end
      cycle();
      n_cmp++; if (out_src !== 2'd1) begin n_err++; $display("FAIL fp_src_n1: got %0d want 1", out_src); end
      n_cmp++; if (out_data !== 4'hB) begin n_err++; $display("FAIL fp_data_n1: got %h want b", out_data); end
      arr_valid = 3'b000;
      cycle();
      n_cmp++; if (hvalid !== 1'b0) begin n_err++; $display("FAIL fp_empty: got %b want 0", hvalid); end
      n_cmp++; if (xfer_count !== 8'd3) begin n_err++; $display("FAIL fp_xfer_end: got %0d want 3", xfer_count); end
   endtask

   task automatic test_stall();
      do_reset();
      arr_valid = 3'b100;
      hready    = 1'b0;
      cycle();
      arr_valid = 3'b010;
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (hvalid !== 1'b1) begin n_err++; $display("FAIL st_valid[%0d]: got %b want 1", k, hvalid); end
         n_cmp++; if (out_src !== 2'd2) begin n_err++; $display("FAIL st_src[%0d]: got %0d want 2", k, out_src); end
         n_cmp++; if (out_data !== 4'hC) begin n_err++; $display("FAIL st_data[%0d]: got %h want c", k, out_data); end
         cycle();
         arr_valid = 3'b000;
      end
      n_cmp++; if (out_data !== 4'hC) begin n_err++; $display("FAIL st_data_end: got %h want c", out_data); end
      hready = 1'b1;
      cycle();
      n_cmp++; if (out_src !== 2'd1) begin n_err++; $display("FAIL st_next_src: got %0d want 1", out_src); end
      cycle();
      n_cmp++; if (hvalid !== 1'b0) begin n_err++; $display("FAIL st_empty: got %b want 0", hvalid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      arr_valid = 3'b010;
      hready    = 1'b1;
      cycle();
      for (int k = 0; k < 7; k++) begin
         cycle();
      end
      hready = 1'b0;
      cycle();
      n_cmp++; if (xfer_count !== 8'd7) begin n_err++; $display("FAIL rm_xfer_pre: got %0d want 7", xfer_count); end
      n_cmp++; if (arr_ready !== 3'b000) begin n_err++; $display("FAIL rm_full: got %b want 000", arr_ready); end
      RESET     = 1'b1;
      arr_valid = 3'b111;
      hready    = 1'b1;
      cycle();
      n_cmp++; if (hvalid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b want 0", hvalid); end
      n_cmp++; if (xfer_count !== 8'd0) begin n_err++; $display("FAIL rm_xfer: got %0d want 0", xfer_count); end
      n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL rm_data: got %h want 0", out_data); end
      RESET = 1'b0;
      #1;
      n_cmp++; if (arr_ready !== 3'b001) begin n_err++; $display("FAIL rm_grant0: got %b want 001", arr_ready); end
      cycle();
      n_cmp++; if (hvalid !== 1'b1) begin n_err++; $display("FAIL rm_valid_after: got %b want 1", hvalid); end
      n_cmp++; if (out_src !== 2'd0) begin n_err++; $display("FAIL rm_src_after: got %0d want 0", out_src); end
      n_cmp++; if (xfer_count !== 8'd0) begin n_err++; $display("FAIL rm_xfer_after: got %0d want 0", xfer_count); end
      arr_valid = 3'b000;
      cycle();
   endtask

   task automatic test_xfer_wrap();
      do_reset();
      arr_valid = 3'b001;
      hready    = 1'b1;
      cycle();
      for (int k = 1; k <= 256; k++) begin
         cycle();
         if (k == 128) begin
            n_cmp++; if (xfer_count !== 8'd128) begin n_err++; $display("FAIL xw_128: got %0d want 128", xfer_count); end
         end
         if (k == 255) begin
            n_cmp++; if (xfer_count !== 8'd255) begin n_err++; $display("FAIL xw_255: got %0d want 255", xfer_count); end
         end
      end
      n_cmp++; if (xfer_count !== 8'd0) begin n_err++; $display("FAIL xw_wrap: got %0d want 0", xfer_count); end
      n_cmp++; if (hvalid !== 1'b1) begin n_err++; $display("FAIL xw_valid: got %b want 1", hvalid); end
      arr_valid = 3'b000;
      cycle();
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      RESET     = 1'b1;
      arr_valid = 3'b000;
      hready    = 1'b0;
      arr_data  = 12'hCBA;
      test_reset();
      test_round_robin();
      test_stall_order();
      test_full_pop();
      test_stall();
      test_reset_mid();
      test_xfer_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
